// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device clock falls, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       PS2_KBCLK,
  input  logic       PS2_KBDAT,
  output logic       ps2_clk_low,
  output logic       ps2_dat_low
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int FW = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT - 1);
  localparam logic [FW-1:0] FRAME_LAST   = FW'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_ABORT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [FW-1:0] frame_timer;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift_reg;

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  logic start_expired;
  logic frame_expired;
  logic nack;
  logic abort_now;

  // NOTE: synchronizers reset to 1 (idle bus) so leaving reset never looks like a fall.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= PS2_KBCLK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= PS2_KBDAT;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // A device fall in RTS wins over the start timeout; the frame timeout wins over everything.
  always_comb begin
    start_expired = 1'b0;
    frame_expired = 1'b0;
    nack          = 1'b0;
    case (state)
      S_RTS:               start_expired = !fall && (timer == START_LAST);
      S_SEND, S_WAIT_IDLE: frame_expired = (frame_timer == FRAME_LAST);
      S_ACK: begin
        frame_expired = (frame_timer == FRAME_LAST);
        nack          = fall && dat_s2;
      end
      default: ;
    endcase
    abort_now = start_expired | frame_expired | nack;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      timer       <= '0;
      frame_timer <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_low <= 1'b0;
      ps2_dat_low <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (abort_now) begin
        state       <= S_ABORT;
        timer       <= '0;
        tx_err      <= 1'b1;
        ps2_clk_low <= 1'b0;
        ps2_dat_low <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            timer       <= '0;
            ps2_clk_low <= 1'b0;
            ps2_dat_low <= 1'b0;
            if (tx_valid && tx_ready) begin
              shift_reg   <= {~^tx_data, tx_data};
              state       <= S_INHIBIT;
              tx_ready    <= 1'b0;
              busy        <= 1'b1;
              ps2_clk_low <= 1'b1;
            end
          end

          S_INHIBIT: begin
            if (timer == INHIBIT_LAST) begin
              state       <= S_RTS;
              timer       <= '0;
              ps2_clk_low <= 1'b0;
              ps2_dat_low <= 1'b1;
            end else if (timer != '1) begin
              timer <= timer + 1'b1;
            end
          end

          // The first device fall puts data bit 0 on the line.
          S_RTS: begin
            if (fall) begin
              state       <= S_SEND;
              timer       <= '0;
              frame_timer <= '0;
              bit_cnt     <= '0;
              ps2_dat_low <= ~shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end else if (timer != '1) begin
              timer <= timer + 1'b1;
            end
          end

          // bit_cnt is the index of the bit currently on the line (8 = parity).
          S_SEND: begin
            if (frame_timer != '1) frame_timer <= frame_timer + 1'b1;
            if (fall) begin
              if (bit_cnt == 4'd8) begin
                state       <= S_ACK;
                bit_cnt     <= 4'd9;
                ps2_dat_low <= 1'b0;
              end else begin
                bit_cnt     <= bit_cnt + 4'd1;
                ps2_dat_low <= ~shift_reg[0];
                shift_reg   <= shift_reg >> 1;
              end
            end
          end

          S_ACK: begin
            if (frame_timer != '1) frame_timer <= frame_timer + 1'b1;
            if (fall) state <= S_WAIT_IDLE;
          end

          S_WAIT_IDLE: begin
            if (frame_timer != '1) frame_timer <= frame_timer + 1'b1;
            if (clk_s2 && dat_s2) begin
              state   <= S_IDLE;
              tx_done <= 1'b1;
            end
          end

          S_ABORT: begin
            state    <= S_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on the wired-AND bus plus a per-cycle
// reference of the handshake outputs; directed frames cover ACK, NACK, timeouts and reset.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int ST  = 300;
  localparam int FT  = 400;
  localparam int H   = 8;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, busy, tx_done, tx_err;
  logic       ps2_clk_low, ps2_dat_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       PS2_KBCLK, PS2_KBDAT;

  assign PS2_KBCLK = ~(ps2_clk_low | dev_clk_low);
  assign PS2_KBDAT = ~(ps2_dat_low | dev_dat_low);

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_pulses = 0;
  int   err_pulses = 0;
  int   last_err_cyc = 0;
  logic exp_busy = 1'b0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (ST),
    .FRAME_TIMEOUT (FT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .PS2_KBCLK  (PS2_KBCLK),
    .PS2_KBDAT  (PS2_KBDAT),
    .ps2_clk_low(ps2_clk_low),
    .ps2_dat_low(ps2_dat_low)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // Frame as the device sees it, bit 0 first: data, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = $countones(d);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  // Reference for the handshake: busy from the accepting edge until the cycle after done/err.
  always @(negedge CLOCK_50) begin
    if (RESET) begin
      exp_busy  = 1'b0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      check("busy", busy, exp_busy);
      check("tx_ready", tx_ready, !exp_busy);
      check("done_err_exclusive", tx_done & tx_err, 0);
      check("clk_and_dat_both_low", ps2_clk_low & ps2_dat_low, 0);
      if (!exp_busy) check("idle_lines_released", {ps2_clk_low, ps2_dat_low}, 0);
      if (tx_err)  check("abort_lines_released", {ps2_clk_low, ps2_dat_low}, 0);
      if (tx_done) check("done_lines_released", {ps2_clk_low, ps2_dat_low}, 0);
      if (tx_done || tx_err) check("pulse_only_when_busy", exp_busy, 1);
      check("done_single_cycle", tx_done & prev_done, 0);
      check("err_single_cycle", tx_err & prev_err, 0);
      if (tx_done) done_pulses++;
      if (tx_err) begin
        err_pulses++;
        last_err_cyc = cyc;
      end
      prev_done = tx_done;
      prev_err  = tx_err;
      if (tx_done || tx_err) exp_busy = 1'b0;
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge CLOCK_50);
    check("ready_before_send", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge CLOCK_50);
    #1;
    exp_busy = 1'b1;
    tx_valid = 1'b0;
  endtask

  // Returns on the first negedge where the host clock pull is gone.
  task automatic measure_inhibit(input string tag);
    int n = 0;
    bit released = 1'b0;
    for (int i = 0; i < INH + 20 && !released; i++) begin
      @(negedge CLOCK_50);
      if (ps2_clk_low) n++;
      else released = 1'b1;
    end
    check({tag, "_inhibit_cycles"}, n, INH);
    check({tag, "_start_bit_on_release"}, ps2_dat_low, 1);
  endtask

  // Device: waits for request-to-send, then clocks `falls` pulses sampling data on each rise.
  task automatic dev_frame(input int falls, input bit ack_low,
                           output logic [9:0] rx, output int first_fall_cyc);
    bit seen = 1'b0;
    rx = '1;
    first_fall_cyc = 0;
    for (int i = 0; i < INH + 50 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (PS2_KBDAT === 1'b0 && PS2_KBCLK === 1'b1) seen = 1'b1;
    end
    check("device_sees_rts", seen, 1);
    if (!seen) return;
    repeat (H) @(negedge CLOCK_50);
    for (int i = 0; i < falls; i++) begin
      if (i == 0) first_fall_cyc = cyc;
      dev_clk_low = 1'b1;
      repeat (H) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
      if (i < 10) rx[i] = PS2_KBDAT;
      repeat (H / 2) @(negedge CLOCK_50);
      if (i == 9 && ack_low) dev_dat_low = 1'b1;
      repeat (H / 2) @(negedge CLOCK_50);
    end
    dev_dat_low = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] rx;
    int ff, d0, e0, rts_cyc, highs;
    bit got;

    RESET = 1'b1;
    settle(3);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_clk_low", ps2_clk_low, 0);
    check("rst_dat_low", ps2_dat_low, 0);
    RESET = 1'b0;
    settle(5);

    // 0xED with ACK
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'hED);
    measure_inhibit("t1");
    dev_frame(11, 1'b1, rx, ff);
    settle(20);
    check("t1_frame_literal", rx, 10'h3ED);
    check("t1_frame_model", rx, model_frame(8'hED));
    check("t1_done_count", done_pulses - d0, 1);
    check("t1_err_count", err_pulses - e0, 0);

    // 0x02 with ACK
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'h02);
    measure_inhibit("t2");
    dev_frame(11, 1'b1, rx, ff);
    settle(20);
    check("t2_frame_literal", rx, 10'h202);
    check("t2_frame_model", rx, model_frame(8'h02));
    check("t2_done_count", done_pulses - d0, 1);
    check("t2_busy_after", busy, 0);

    // NACK
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'h55);
    dev_frame(11, 1'b0, rx, ff);
    settle(20);
    check("t3_frame_model", rx, model_frame(8'h55));
    check("t3_err_count", err_pulses - e0, 1);
    check("t3_done_count", done_pulses - d0, 0);

    // Device never clocks
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'hAA);
    measure_inhibit("t4");
    rts_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < ST + 20 && !got; i++) begin
      @(negedge CLOCK_50);
      if (err_pulses != e0) got = 1'b1;
    end
    check("t4_err_seen", got, 1);
    check("t4_start_timeout_cycles", last_err_cyc - rts_cyc, ST);
    settle(5);
    check("t4_done_count", done_pulses - d0, 0);

    // Device stops after 4 falls
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'h12);
    dev_frame(4, 1'b0, rx, ff);
    got = 1'b0;
    for (int i = 0; i < FT + 50 && !got; i++) begin
      @(negedge CLOCK_50);
      if (err_pulses != e0) got = 1'b1;
    end
    check("t5_err_seen", got, 1);
    check_range("t5_frame_timeout_cycles", last_err_cyc - ff, FT + 2, FT + 4);
    check("t5_bits_0_3", rx[3:0], 4'h2);
    settle(5);
    check("t5_done_count", done_pulses - d0, 0);

    // Asynchronous reset while bit 5 of 0x5A (a 0) is on the line
    e0 = err_pulses;
    start_tx(8'h5A);
    dev_frame(6, 1'b0, rx, ff);
    check("t6_bits_0_4", rx[4:0], 5'h1A);
    check("t6_bit5_driven_low", ps2_dat_low, 1);
    @(negedge CLOCK_50);
    #3;
    RESET = 1'b1;
    #1;
    check("t6_async_clk_low", ps2_clk_low, 0);
    check("t6_async_dat_low", ps2_dat_low, 0);
    check("t6_async_tx_ready", tx_ready, 1);
    check("t6_async_tx_err", tx_err, 0);
    settle(3);
    RESET = 1'b0;
    settle(5);
    check("t6_no_err_pulse", err_pulses - e0, 0);

    // 0xFF offered mid-frame must be dropped
    d0 = done_pulses;
    start_tx(8'h02);
    settle(5);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    settle(3);
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, rx, ff);
    settle(20);
    check("t6_frame_unchanged", rx, 10'h202);
    check("t6_done_count", done_pulses - d0, 1);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      if (ps2_clk_low || busy) highs++;
    end
    check("t6_nothing_queued", highs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
